// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   op_e       - Op port encodings (MULT, MULTU, DIV, DIVU)
//   state_e    - control FSM states (IDLE, RUN, DONE)
//   cfg_legal  - DATA_W / BITS_PER_CYCLE legality check used at elaboration
//   op_is_div / op_is_signed - Op decode helpers
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Width must be even and >= 4; the step width must divide it exactly so
    // the iteration count is an integer.
    function automatic bit cfg_legal(input int unsigned data_w,
                                     input int unsigned bpc);
        return (data_w >= 4) && ((data_w % 2) == 0) &&
               ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               ((data_w % bpc) == 0);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// -----------------------------------------------------------------------------
// muldiv_iter_step
// Combinational iteration step of the multiply/divide datapath. Resolves
// BITS_PER_CYCLE product bits (shift-add) or quotient bits (restoring
// subtract) per call.
//   i_div     - 1: restoring-divide step, 0: shift-add multiply step
//               (port present only when MULDIV_DIV_EN is defined)
//   i_acc     - multiply: upper product accumulator; divide: partial remainder
//   i_shreg   - multiply: remaining multiplier bits / lower product;
//               divide: remaining dividend bits / quotient
//   i_operand - multiply: multiplicand magnitude; divide: divisor magnitude
//   o_acc, o_shreg - updated i_acc / i_shreg after BITS_PER_CYCLE bits
// Config macro: MULDIV_DIV_EN (enables the divide step).
// -----------------------------------------------------------------------------
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
`ifdef MULDIV_DIV_EN
    input  logic              i_div,
`endif
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_shreg,
    input  logic [DATA_W-1:0] i_operand,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_shreg
);

    logic [DATA_W-1:0] w_acc;
    logic [DATA_W-1:0] w_sh;
    logic [DATA_W:0]   w_sum;
`ifdef MULDIV_DIV_EN
    logic [DATA_W:0]   w_rem;
    logic [DATA_W:0]   w_diff;
`endif

    always_comb begin
        w_acc  = i_acc;
        w_sh   = i_shreg;
        w_sum  = '0;
`ifdef MULDIV_DIV_EN
        w_rem  = '0;
        w_diff = '0;
`endif
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
`ifdef MULDIV_DIV_EN
            if (i_div) begin
                // Bring the next dividend bit into the remainder; keep the
                // trial difference only if it did not borrow.
                w_rem  = {w_acc, w_sh[DATA_W-1]};
                w_diff = w_rem - {1'b0, i_operand};
                if (!w_diff[DATA_W]) begin
                    w_acc = w_diff[DATA_W-1:0];
                    w_sh  = {w_sh[DATA_W-2:0], 1'b1};
                end else begin
                    w_acc = w_rem[DATA_W-1:0];
                    w_sh  = {w_sh[DATA_W-2:0], 1'b0};
                end
            end else
`endif
            begin
                // Add multiplicand when the current multiplier bit is set,
                // then shift the whole {carry, acc, shreg} right by one.
                w_sum         = {1'b0, w_acc} + (w_sh[0] ? {1'b0, i_operand} : '0);
                {w_acc, w_sh} = {w_sum, w_sh[DATA_W-1:1]};
            end
        end
    end

    assign o_acc   = w_acc;
    assign o_shreg = w_sh;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MIPS-style multiply/divide unit. Signed operations iterate on
// magnitudes and apply the result sign in the final cycle.
//   Clk        - clock, all state on rising edge
//   Reset      - synchronous active-high reset
//   Start      - request, sampled only in IDLE
//   Op         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA   - rs: multiplicand / dividend
//   OperandB   - rt: multiplier / divisor
//   Flush      - abort the in-flight operation
//   Busy       - operation in flight
//   Done       - one-cycle pulse, Hi/Lo valid
//   Hi, Lo     - result registers ({Hi,Lo} product; Hi=remainder, Lo=quotient)
//   DivByZero  - divisor was zero, qualified by Done
// Config macro: MULDIV_DIV_EN - builds the divider; when undefined, divide
// requests are ignored and DivByZero is tied low.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] OperandA,
    input  logic [DATA_W-1:0] OperandB,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic              DivByZero
);

    localparam int unsigned ITERS = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    if (!cfg_legal(DATA_W, BITS_PER_CYCLE)) begin : g_cfg_check
        $error("muldiv_unit: illegal DATA_W / BITS_PER_CYCLE combination");
    end

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_sh;
    logic [DATA_W-1:0]   r_opnd;
    logic                r_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    op_e                 w_op;
    logic                w_is_div;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic                w_accept;
    logic [DATA_W-1:0]   w_step_acc;
    logic [DATA_W-1:0]   w_step_sh;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fin;
    logic [DATA_W-1:0]   w_quo_fin;
    logic [DATA_W-1:0]   w_rem_fin;
    logic [DATA_W-1:0]   w_hi_fin;
    logic [DATA_W-1:0]   w_lo_fin;

    // ---- operand decode and magnitude conversion ----
    assign w_op     = op_e'(Op);
    assign w_is_div = op_is_div(w_op);
    assign w_signed = op_is_signed(w_op);
    assign w_a_neg  = w_signed & OperandA[DATA_W-1];
    assign w_b_neg  = w_signed & OperandB[DATA_W-1];
    assign w_a_mag  = w_a_neg ? (~OperandA + 1'b1) : OperandA;
    assign w_b_mag  = w_b_neg ? (~OperandB + 1'b1) : OperandB;

`ifdef MULDIV_DIV_EN
    logic w_b_zero;
    logic r_dbz;
    assign w_b_zero  = (OperandB == '0);
    assign w_accept  = Start;
    assign DivByZero = r_dbz;
`else
    assign w_accept  = Start & ~w_is_div;
    assign DivByZero = 1'b0;
`endif

    muldiv_iter_step #(
        .DATA_W         (DATA_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
`ifdef MULDIV_DIV_EN
        .i_div     (r_div),
`endif
        .i_acc     (r_acc),
        .i_shreg   (r_sh),
        .i_operand (r_opnd),
        .o_acc     (w_step_acc),
        .o_shreg   (w_step_sh)
    );

    // ---- final sign correction ----
    // Quotient/product sign is the XOR of operand signs; remainder takes
    // the dividend sign. Most-negative / -1 falls out naturally: the
    // magnitude quotient 2^(W-1) re-reads as the most-negative value.
    assign w_prod     = {r_acc, r_sh};
    assign w_prod_fin = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fin  = r_neg_q ? (~r_sh + 1'b1)   : r_sh;
    assign w_rem_fin  = r_neg_r ? (~r_acc + 1'b1)  : r_acc;
    assign w_hi_fin   = r_div ? w_rem_fin : w_prod_fin[2*DATA_W-1:DATA_W];
    assign w_lo_fin   = r_div ? w_quo_fin : w_prod_fin[DATA_W-1:0];

    // ---- control FSM and result registers ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sh    <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MULDIV_DIV_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_div   <= w_is_div;
                        r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                        r_sh    <= w_is_div ? w_a_mag : w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
`ifdef MULDIV_DIV_EN
                        if (w_is_div && w_b_zero) begin
                            // Zero divisor: no iterations, report immediately.
                            r_hi    <= OperandA;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else
`endif
                        begin
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(ITERS)) begin
                        r_hi    <= w_hi_fin;
                        r_lo    <= w_lo_fin;
`ifdef MULDIV_DIV_EN
                        r_dbz   <= 1'b0;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc <= w_step_acc;
                        r_sh  <= w_step_sh;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width, even, >=4.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient/product bits resolved per iteration, legal 1/2/4, DATA_W % BITS_PER_CYCLE == 0.
REQ-003 SHALL have port Clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have ports OperandA, OperandB  in  DATA_W  rs (multiplicand/dividend), rt (multiplier/divisor).
REQ-008 SHALL have port Flush  in  1  abort the in-flight operation.
REQ-009 SHALL have port Busy  out  1  operation in flight; drives pipeline stall.
REQ-010 SHALL have port Done  out  1  one-cycle pulse, Hi/Lo valid.
REQ-011 SHALL have ports Hi, Lo  out  DATA_W  result registers, held until next Done.
REQ-012 SHALL have port DivByZero  out  1  qualified by Done.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE->RUN on Start; RUN->DONE after DATA_W/BITS_PER_CYCLE iterations; DONE->IDLE unconditionally.
REQ-014 SHALL latch Op and operands on the Clk edge that accepts Start; Busy high from the next cycle until Done.
REQ-015 SHALL assert Done exactly one cycle, DATA_W/BITS_PER_CYCLE+1 cycles after the accept edge; Busy low in that cycle.
REQ-016 SHALL update Hi/Lo only on the edge that asserts Done.
REQ-017 SHALL ignore Start while Busy or Done are high.
REQ-018 SHALL compute MULT/MULTU as a full 2*DATA_W product, {Hi,Lo}, signed via magnitude iteration plus final negate.
REQ-019 SHALL compute DIV/DIVU by restoring division: Lo = quotient, Hi = remainder; signed quotient truncates toward zero; remainder sign follows dividend.
REQ-020 SHALL, for signed most-negative / -1, give Lo = most-negative value, Hi = 0, no flag.
REQ-021 SHALL, for divisor 0, skip RUN, assert Done next cycle with Hi = OperandA, Lo = all ones, DivByZero = 1.
REQ-022 SHALL, on Flush while Busy, return to IDLE next cycle, deassert Busy, leave Hi/Lo unchanged, produce no Done; Flush in IDLE has no effect.
REQ-023 SHALL give Flush priority over completion when both fall on the same edge.

Reset
REQ-024 SHALL, when Reset is high at a Clk edge, force IDLE, Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0.
REQ-025 SHALL give Reset priority over Flush and Start, including mid-operation, with no Done.

Configuration
REQ-026 SHALL compile the divider only when macro MULDIV_DIV_EN is defined.
REQ-027 SHALL, without MULDIV_DIV_EN, ignore Start with Op[1]=1 (no Busy, no Done), tie DivByZero to 0, and keep multiply behaviour unchanged.

Structure
REQ-028 SHALL place the Op encodings, FSM state encodings and the DATA_W % BITS_PER_CYCLE legality check in shared package muldiv_pkg.
REQ-029 SHALL use one sub-module, muldiv_iter_step: combinational BITS_PER_CYCLE-bit shift-add / restoring-subtract step.

Verification (DATA_W=32, BITS_PER_CYCLE=1, MULDIV_DIV_EN defined unless stated)
REQ-030 SHALL cover MULT 0xFFFFFFFE x 0x00000003 -> Done 33 cycles after accept, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
REQ-031 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; repeat with BITS_PER_CYCLE=4 -> Done after 9 cycles.
REQ-032 SHALL cover DIV 0xFFFFFFF9 / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-033 SHALL cover DIVU 0x0000000A / 0 -> Done next cycle, DivByZero=1, Hi=0x0000000A, Lo=0xFFFFFFFF.
REQ-034 SHALL cover MULT with Flush at iteration 10 and Start pulsed during Busy -> Busy low next cycle, no Done, Hi/Lo keep prior result, the second Start is not accepted.
REQ-035 SHALL cover Reset mid-DIV -> all outputs 0 next cycle; without MULDIV_DIV_EN, Start with Op=10 -> Busy stays 0.
